// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: decodes op/funct and sequences
// fetch, decode, execute, memory and writeback, stretching memory states on memready.
module multicycle_ctrl #(
    parameter bit FETCH_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       regdst,
    output logic       memtoreg,
    output logic       immExt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    state_t state_q, state_d;

    logic       is_rtype, is_lw, is_sw, is_beq, is_bne, is_imm, is_j;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic [2:0] imm_alu;
    logic       imm_zext;

    always_comb begin
        is_rtype = (op == 6'b000000);
        is_lw    = (op == 6'b100011);
        is_sw    = (op == 6'b101011);
        is_beq   = (op == 6'b000100);
        is_bne   = (op == 6'b000101);
        is_j     = (op == 6'b000010);
        is_imm   = 1'b1;
        imm_alu  = 3'b010;
        imm_zext = 1'b0;
        case (op)
            6'b001000: imm_alu = 3'b010;
            6'b001100: begin imm_alu = 3'b000; imm_zext = 1'b1; end
            6'b001101: begin imm_alu = 3'b001; imm_zext = 1'b1; end
            6'b001010: imm_alu = 3'b111;
            default:   is_imm = 1'b0;
        endcase
    end

    // Unknown funct falls back to add but is flagged so the writeback is skipped.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_lw || is_sw)       state_d = S_MEMADR;
                else if (is_rtype)        state_d = S_RTYPEEX;
                else if (is_beq || is_bne) state_d = S_BRANCH;
                else if (is_imm)          state_d = S_IMMEX;
                else if (is_j)            state_d = S_JUMP;
                else                      state_d = FETCH_ON_ILLEGAL ? S_FETCH : S_HALT;
            end
            S_MEMADR:  state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = funct_ok ? S_RTYPEWB : S_FETCH;
            S_IMMEX:   state_d = S_IMMWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcen       = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        immExt     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = memready;
                pcen    = memready;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = is_bne ? ~zero : zero;
            end
            S_IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = imm_alu;
                immExt     = imm_zext;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                alucontrol = imm_alu;
                immExt     = imm_zext;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        // Reset forces FETCH, whose pcen/irwrite follow memready, so gate explicitly.
        if (!reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expected state sequences
// and per-state output values, checked cycle by cycle on two parameterizations.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcen, irwrite, regwrite, memwrite, iord, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic       regdst, memtoreg, immext;
    } outs_t;

    logic clk = 1'b0, reset = 1'b0;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, memready = 1'b0;

    logic pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, immExt;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic pcen_h, irwrite_h, regwrite_h, memwrite_h, iord_h, alusrca_h, regdst_h, memtoreg_h, immExt_h;
    logic [1:0] alusrcb_h, pcsrc_h;
    logic [2:0] alucontrol_h;
    logic [3:0] state_h;

    int n_tests = 0, n_fail = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg), .immExt(immExt),
        .state(state)
    );

    multicycle_ctrl #(.FETCH_ON_ILLEGAL(1'b0)) dut_h (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen_h), .irwrite(irwrite_h), .regwrite(regwrite_h), .memwrite(memwrite_h),
        .iord(iord_h), .alusrca(alusrca_h), .alusrcb(alusrcb_h), .pcsrc(pcsrc_h),
        .alucontrol(alucontrol_h), .regdst(regdst_h), .memtoreg(memtoreg_h), .immExt(immExt_h),
        .state(state_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit r_ok(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] o);
        case (o)
            6'h0c:   return 3'b000;
            6'h0d:   return 3'b001;
            6'h0a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_immop(input logic [5:0] o);
        return o == 6'h08 || o == 6'h0c || o == 6'h0d || o == 6'h0a;
    endfunction

    // Signals each state asserts; everything unlisted is 0 and the ALU adds.
    function automatic outs_t ref_outs(input int s, input logic [5:0] o, input logic [5:0] f,
                                       input logic z, input logic mr);
        outs_t r;
        r = '0;
        r.aluc = 3'b010;
        case (s)
            0:  begin r.alusrcb = 2'b01; r.irwrite = mr; r.pcen = mr; end
            1:  r.alusrcb = 2'b11;
            2:  begin r.alusrca = 1'b1; r.alusrcb = 2'b10; end
            3:  r.iord = 1'b1;
            4:  begin r.memtoreg = 1'b1; r.regwrite = 1'b1; end
            5:  begin r.iord = 1'b1; r.memwrite = 1'b1; end
            6:  begin r.alusrca = 1'b1; r.aluc = r_alu(f); end
            7:  begin r.regdst = 1'b1; r.regwrite = 1'b1; end
            8:  begin r.alusrca = 1'b1; r.aluc = 3'b110; r.pcsrc = 2'b01;
                      r.pcen = (o == 6'h05) ? ~z : z; end
            9:  begin r.alusrca = 1'b1; r.alusrcb = 2'b10; r.aluc = i_alu(o);
                      r.immext = (o == 6'h0c || o == 6'h0d); end
            10: begin r.regwrite = 1'b1; r.aluc = i_alu(o);
                      r.immext = (o == 6'h0c || o == 6'h0d); end
            11: begin r.pcsrc = 2'b10; r.pcen = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fs fetch stalls, ms data-memory stalls, zmode<0 = random zero.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fs,
                             input int ms, input int zmode);
        int sq[$];
        bit mq[$];
        outs_t act, exp;
        for (int i = 0; i < fs; i++) begin sq.push_back(0); mq.push_back(1'b0); end
        sq.push_back(0); mq.push_back(1'b1);
        sq.push_back(1); mq.push_back(rbit());
        if (o == 6'h23) begin
            sq.push_back(2); mq.push_back(rbit());
            for (int i = 0; i < ms; i++) begin sq.push_back(3); mq.push_back(1'b0); end
            sq.push_back(3); mq.push_back(1'b1);
            sq.push_back(4); mq.push_back(rbit());
        end else if (o == 6'h2b) begin
            sq.push_back(2); mq.push_back(rbit());
            for (int i = 0; i < ms; i++) begin sq.push_back(5); mq.push_back(1'b0); end
            sq.push_back(5); mq.push_back(1'b1);
        end else if (o == 6'h00) begin
            sq.push_back(6); mq.push_back(rbit());
            if (r_ok(f)) begin sq.push_back(7); mq.push_back(rbit()); end
        end else if (o == 6'h04 || o == 6'h05) begin
            sq.push_back(8); mq.push_back(rbit());
        end else if (is_immop(o)) begin
            sq.push_back(9); mq.push_back(rbit());
            sq.push_back(10); mq.push_back(rbit());
        end else if (o == 6'h02) begin
            sq.push_back(11); mq.push_back(rbit());
        end
        for (int k = 0; k < sq.size(); k++) begin
            op = o;
            funct = f;
            memready = mq[k];
            zero = (zmode < 0) ? rbit() : zmode[0];
            #1;
            chk($sformatf("state op=%0h k=%0d", o, k), 32'(state), 32'(sq[k]));
            chk($sformatf("state_h op=%0h k=%0d", o, k), 32'(state_h), 32'(sq[k]));
            act = '{pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb, pcsrc,
                    alucontrol, regdst, memtoreg, immExt};
            exp = ref_outs(sq[k], o, f, zero, memready);
            chk($sformatf("outs op=%0h f=%0h s=%0d", o, f, sq[k]), 32'(act), 32'(exp));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] fns [5];
        logic [5:0] o, f;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

        // Reset held with memready high: FETCH, no enables.
        memready = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst state", 32'(state), 32'd0);
            chk("rst enables", 32'({pcen, irwrite, regwrite, memwrite}), 32'd0);
            chk("rst enables_h", 32'({pcen_h, irwrite_h, regwrite_h, memwrite_h}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release irwrite/pcen", 32'({irwrite, pcen}), 32'b11);
        @(negedge clk);
        #1;
        chk("release decode", 32'(state), 32'd1);
        // Mid-instruction async reset takes effect without a clock edge.
        reset = 1'b0;
        #1;
        chk("async rst state", 32'(state), 32'd0);
        chk("async rst enables", 32'({pcen, irwrite, regwrite, memwrite}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_instr(6'h23, 6'h00, 0, 2, -1);
        run_instr(6'h04, 6'h00, 0, 0, 1);
        run_instr(6'h05, 6'h00, 0, 0, 1);
        run_instr(6'h05, 6'h00, 1, 0, 0);
        run_instr(6'h0d, 6'h00, 0, 0, -1);
        run_instr(6'h00, 6'h2a, 0, 0, -1);
        run_instr(6'h00, 6'h3f, 0, 0, -1);
        run_instr(6'h2b, 6'h00, 2, 1, -1);
        run_instr(6'h02, 6'h00, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 10)];
            f = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        // Illegal opcode: default instance refetches, the other parks in HALT.
        op = 6'h3f;
        memready = 1'b1;
        #1;
        chk("ill fetch", 32'(state), 32'd0);
        @(negedge clk);
        #1;
        chk("ill decode", 32'(state_h), 32'd1);
        @(negedge clk);
        #1;
        chk("ill refetch", 32'(state), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("halt state", 32'(state_h), 32'd15);
            chk("halt enables", 32'({pcen_h, irwrite_h, regwrite_h, memwrite_h}), 32'd0);
            @(negedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("halt reset", 32'(state_h), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
